// File: rtl/ni_crc32_checker.sv
// Per-virtual-channel CRC32 checker for the NI receive path (poly 0x04C11DB7, init 0, no reflection).
// Define NI_CRC_ERR_CNT_EN to build the saturating mismatch counter; otherwise err_cnt is tied to 0.
module ni_crc32_checker #(
  parameter int unsigned CHANNEL   = 4,
  parameter int unsigned ERR_CNT_W = 16,
  localparam int unsigned CHw      = (CHANNEL > 1) ? $clog2(CHANNEL) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flit_wr,
  input  logic [CHw-1:0]       flit_channel,
  input  logic                 flit_is_head,
  input  logic                 flit_is_tail,
  input  logic [31:0]          data_in,
  input  logic                 err_clr,
  output logic                 crc_done,
  output logic [CHw-1:0]       crc_done_channel,
  output logic                 crc_ok,
  output logic                 proto_err,
  output logic [CHANNEL-1:0]   err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} ch_state_e;

  ch_state_e          st_q  [CHANNEL];
  ch_state_e          st_d  [CHANNEL];
  logic [31:0]        acc_q [CHANNEL];
  logic [31:0]        acc_d [CHANNEL];
  logic               crc_done_q, crc_done_d;
  logic [CHw-1:0]     done_ch_q, done_ch_d;
  logic               crc_ok_q, crc_ok_d;
  logic               proto_err_q, proto_err_d;
  logic [CHANNEL-1:0] sticky_q, sticky_d;

  logic               ch_valid_c;
  logic [31:0]        acc_cur_c;
  logic [31:0]        crc_next_c;
  logic               mismatch_c;

  // MSB-first serial definition unrolled into the 32-bit parallel XOR matrix
  function automatic logic [31:0] crc32_f(input logic [31:0] crc, input logic [31:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ d[i]) c = {c[30:0], 1'b0} ^ POLY;
      else              c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  assign ch_valid_c = (32'(flit_channel) < CHANNEL);
  assign acc_cur_c  = acc_q[flit_channel];
  // One shared matrix; a head flit restarts from the zero seed
  assign crc_next_c = crc32_f(flit_is_head ? 32'h0 : acc_cur_c, data_in);

  always_comb begin
    st_d        = st_q;
    acc_d       = acc_q;
    crc_done_d  = 1'b0;
    done_ch_d   = done_ch_q;
    crc_ok_d    = 1'b0;
    proto_err_d = 1'b0;
    if (flit_wr && ch_valid_c) begin
      unique case ({flit_is_head, flit_is_tail})
        2'b10: begin
          proto_err_d         = (st_q[flit_channel] == ACC);
          acc_d[flit_channel] = crc_next_c;
          st_d[flit_channel]  = ACC;
        end
        2'b00: begin
          if (st_q[flit_channel] == ACC) acc_d[flit_channel] = crc_next_c;
          else                           proto_err_d = 1'b1;
        end
        2'b01: begin
          if (st_q[flit_channel] == ACC) begin
            crc_done_d          = 1'b1;
            done_ch_d           = flit_channel;
            crc_ok_d            = (data_in == acc_cur_c);
            acc_d[flit_channel] = 32'h0;
            st_d[flit_channel]  = IDLE;
          end else begin
            proto_err_d = 1'b1;
          end
        end
        default: begin
          // Single-flit packet: payload is empty, so the expected CRC is 0
          proto_err_d         = (st_q[flit_channel] == ACC);
          crc_done_d          = 1'b1;
          done_ch_d           = flit_channel;
          crc_ok_d            = (data_in == 32'h0);
          acc_d[flit_channel] = 32'h0;
          st_d[flit_channel]  = IDLE;
        end
      endcase
    end
  end

  assign mismatch_c = crc_done_d & ~crc_ok_d;

  always_comb begin
    sticky_d = sticky_q;
    if (err_clr)         sticky_d = '0;
    else if (mismatch_c) sticky_d[flit_channel] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(CHANNEL); i++) begin
        st_q[i]  <= IDLE;
        acc_q[i] <= 32'h0;
      end
      crc_done_q  <= 1'b0;
      done_ch_q   <= '0;
      crc_ok_q    <= 1'b0;
      proto_err_q <= 1'b0;
      sticky_q    <= '0;
    end else begin
      st_q        <= st_d;
      acc_q       <= acc_d;
      crc_done_q  <= crc_done_d;
      done_ch_q   <= done_ch_d;
      crc_ok_q    <= crc_ok_d;
      proto_err_q <= proto_err_d;
      sticky_q    <= sticky_d;
    end
  end

`ifdef NI_CRC_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count; a clear in the same cycle wins over the mismatch
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr)                            err_cnt_d = '0;
    else if (mismatch_c && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = '0;
`endif

  assign crc_done         = crc_done_q;
  assign crc_done_channel = done_ch_q;
  assign crc_ok           = crc_ok_q;
  assign proto_err        = proto_err_q;
  assign err_sticky       = sticky_q;

endmodule

// File: tb/tb_ni_crc32_checker.sv
// Scoreboard bench for ni_crc32_checker: directed flits push expected results, a monitor checks them.
module tb_ni_crc32_checker;

`ifdef NI_CRC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flit_wr = 1'b0;
  logic [1:0]  flit_channel = '0;
  logic        flit_is_head = 1'b0;
  logic        flit_is_tail = 1'b0;
  logic [31:0] data_in = '0;
  logic        err_clr = 1'b0;
  logic        crc_done;
  logic [1:0]  crc_done_channel;
  logic        crc_ok;
  logic        proto_err;
  logic [3:0]  err_sticky;
  logic [1:0]  err_cnt;

  ni_crc32_checker #(.CHANNEL(4), .ERR_CNT_W(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .flit_wr          (flit_wr),
    .flit_channel     (flit_channel),
    .flit_is_head     (flit_is_head),
    .flit_is_tail     (flit_is_tail),
    .data_in          (data_in),
    .err_clr          (err_clr),
    .crc_done         (crc_done),
    .crc_done_channel (crc_done_channel),
    .crc_ok           (crc_ok),
    .proto_err        (proto_err),
    .err_sticky       (err_sticky),
    .err_cnt          (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] ch;
    logic       ok;
  } done_exp_t;

  done_exp_t done_q[$];
  int        proto_q[$];
  int        cyc = 0;
  int        n_tests = 0;
  int        n_fail = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: outputs are stable at the falling edge
  always @(negedge clk) begin
    if (reset) begin
      if (crc_done) begin
        if (done_q.size() == 0) begin
          check("unexpected_crc_done", 32'(crc_done), 32'd0);
        end else begin
          done_exp_t e;
          e = done_q.pop_front();
          check("crc_done_cycle", 32'(cyc), 32'(e.cyc));
          check("crc_done_channel", 32'(crc_done_channel), 32'(e.ch));
          check("crc_ok", 32'(crc_ok), 32'(e.ok));
        end
      end
      if (proto_err) begin
        if (proto_q.size() == 0) begin
          check("unexpected_proto_err", 32'(proto_err), 32'd0);
        end else begin
          int c;
          c = proto_q.pop_front();
          check("proto_err_cycle", 32'(cyc), 32'(c));
        end
      end
    end
  end

  task automatic send(input logic [1:0] ch, input logic hd, input logic tl, input logic [31:0] d,
                      input logic exp_done, input logic exp_ok, input logic exp_proto,
                      input logic clr = 1'b0);
    @(negedge clk);
    flit_wr      = 1'b1;
    flit_channel = ch;
    flit_is_head = hd;
    flit_is_tail = tl;
    data_in      = d;
    err_clr      = clr;
    if (exp_done) done_q.push_back('{cyc + 1, ch, exp_ok});
    if (exp_proto) proto_q.push_back(cyc + 1);
  endtask

  task automatic idle(input logic clr = 1'b0);
    @(negedge clk);
    flit_wr      = 1'b0;
    flit_is_head = 1'b0;
    flit_is_tail = 1'b0;
    err_clr      = clr;
  endtask

  initial begin
    #1;
    check("reset_crc_done", 32'(crc_done), 32'd0);
    check("reset_sticky", 32'(err_sticky), 32'd0);
    check("reset_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // Basic pass on channel 0
    send(2'd0, 1, 0, 32'h0000_0001, 0, 0, 0);
    send(2'd0, 0, 1, 32'h04C1_1DB7, 1, 1, 0);
    idle();
    check("basic_sticky", 32'(err_sticky), 32'd0);
    check("basic_err_cnt", 32'(err_cnt), 32'd0);

    // Mismatch on channel 1, then clear
    send(2'd1, 1, 0, 32'h0000_0001, 0, 0, 0);
    send(2'd1, 0, 1, 32'h04C1_1DB6, 1, 0, 0);
    idle();
    check("mismatch_sticky", 32'(err_sticky), 32'h2);
    check("mismatch_err_cnt", 32'(err_cnt), CNT_EN ? 32'd1 : 32'd0);
    idle(1'b1);
    idle();
    check("clr_sticky", 32'(err_sticky), 32'd0);
    check("clr_err_cnt", 32'(err_cnt), 32'd0);

    // Interleaved channels 2 and 3, back to back
    send(2'd2, 1, 0, 32'h0000_0001, 0, 0, 0);
    send(2'd3, 1, 0, 32'h0000_0000, 0, 0, 0);
    send(2'd3, 0, 0, 32'h0000_0000, 0, 0, 0);
    send(2'd2, 0, 1, 32'h04C1_1DB7, 1, 1, 0);
    send(2'd3, 0, 1, 32'h0000_0000, 1, 1, 0);
    // Head directly after tail, body updates: f(f(0,0),1) = POLY
    send(2'd3, 1, 0, 32'h0000_0000, 0, 0, 0);
    send(2'd3, 0, 0, 32'h0000_0001, 0, 0, 0);
    send(2'd3, 0, 1, 32'h04C1_1DB7, 1, 1, 0);
    idle();
    check("interleave_sticky", 32'(err_sticky), 32'd0);

    // Protocol errors on idle channel 0
    send(2'd0, 0, 0, 32'h1234_5678, 0, 0, 1);
    send(2'd0, 0, 1, 32'h0000_0000, 0, 0, 1);
    // Single-flit packets
    send(2'd1, 1, 1, 32'h0000_0000, 1, 1, 0);
    send(2'd1, 1, 1, 32'h0000_0005, 1, 0, 0);
    idle();
    check("single_sticky", 32'(err_sticky), 32'h2);
    check("single_err_cnt", 32'(err_cnt), CNT_EN ? 32'd1 : 32'd0);
    // Head while accumulating restarts; head+tail while accumulating
    send(2'd2, 1, 0, 32'hDEAD_BEEF, 0, 0, 0);
    send(2'd2, 1, 0, 32'h0000_0001, 0, 0, 1);
    send(2'd2, 0, 1, 32'h04C1_1DB7, 1, 1, 0);
    send(2'd3, 1, 0, 32'h0000_0001, 0, 0, 0);
    send(2'd3, 1, 1, 32'h0000_0000, 1, 1, 1);
    // Channel 3 is idle again, so its tail is a protocol error
    send(2'd3, 0, 1, 32'h04C1_1DB7, 0, 0, 1);

    // Clear wins over a simultaneous mismatch
    idle(1'b1);
    send(2'd0, 1, 1, 32'h0000_0007, 1, 0, 0, 1'b1);
    idle();
    check("clr_prio_sticky", 32'(err_sticky), 32'd0);
    check("clr_prio_err_cnt", 32'(err_cnt), 32'd0);

    // Counter saturation
    for (int i = 0; i < 5; i++) send(2'd0, 1, 1, 32'h0000_0005, 1, 0, 0);
    idle();
    check("sat_sticky", 32'(err_sticky), 32'h1);
    check("sat_err_cnt", 32'(err_cnt), CNT_EN ? 32'd3 : 32'd0);

    // Reset mid-packet clears everything at once
    send(2'd1, 1, 0, 32'h0000_0001, 0, 0, 0);
    send(2'd0, 1, 1, 32'h0000_0009, 1, 0, 0);
    idle();
    #2 reset = 1'b0;
    #1;
    check("async_rst_sticky", 32'(err_sticky), 32'd0);
    check("async_rst_err_cnt", 32'(err_cnt), 32'd0);
    check("async_rst_done", 32'(crc_done), 32'd0);
    check("async_rst_ok", 32'(crc_ok), 32'd0);
    check("async_rst_proto", 32'(proto_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    send(2'd1, 0, 1, 32'h04C1_1DB7, 0, 0, 1);
    idle();
    idle();
    idle();

    check("done_queue_empty", 32'(done_q.size()), 32'd0);
    check("proto_queue_empty", 32'(proto_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ni_crc32_checker.md
# ni_crc32_checker

Receive-side counterpart of the network interface CRC32 generator. It runs the same 32-bit-per-cycle CRC32 update (polynomial 0x04C11DB7, initial value 0, no reflection, no final XOR) independently for each virtual channel on incoming packet flits. On each tail flit it compares the accumulated value with the CRC word the tail carries and reports pass or fail. It sits in the NI receive path between the router ejection port and the packet buffer, and also keeps per-channel sticky error flags and an error counter.

## Interface
- `CHANNEL`, default 4: number of virtual channels; `CHw = log2(CHANNEL)`, minimum 1.
- `ERR_CNT_W`, default 16: width of the saturating error counter.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state while low.
- `flit_wr` in 1: a flit is present this cycle. There is no back-pressure; the block accepts every flit.
- `flit_channel` in CHw: virtual channel of the flit.
- `flit_is_head` in 1: the flit is the first flit of a packet.
- `flit_is_tail` in 1: the flit is the last flit of a packet. Its data is the transmitted CRC word.
- `data_in` in 32: flit payload.
- `err_clr` in 1: clears the sticky flags and the error counter.
- `crc_done` out 1: one-cycle pulse giving the result of a tail flit.
- `crc_done_channel` out CHw: channel that `crc_done` refers to.
- `crc_ok` out 1: valid with `crc_done`; high when the CRC matches.
- `proto_err` out 1: one-cycle pulse on an illegal flit sequence.
- `err_sticky` out CHANNEL: per-channel flag, set on a CRC mismatch.
- `err_cnt` out ERR_CNT_W: total number of CRC mismatches, saturating.

## Operation
- Per-channel state is IDLE or ACC, plus a 32-bit register `acc[ch]`. Reset value: IDLE, 0.
- The next-CRC function is `f(crc, d)`, the standard CRC32 32-bit-parallel XOR matrix. Only the selected channel's register and state change in a given cycle.
- Head flit (head=1, tail=0):
  - In IDLE: `acc <= f(0, data_in)`, next state ACC.
  - In ACC: same update, restarting the accumulation, and `proto_err` pulses.
- Body flit (head=0, tail=0):
  - In ACC: `acc <= f(acc, data_in)`.
  - In IDLE: the flit is ignored and `proto_err` pulses.
- Tail flit (head=0, tail=1):
  - In ACC: compare `data_in == acc`. Then `acc <= 0` and next state IDLE.
  - In IDLE: `proto_err` pulses and no `crc_done` is produced.
- Single-flit packet (head=1, tail=1): the flit carries only the CRC word. Expected value is 0, the CRC of an empty payload. Compare `data_in == 0`, regardless of state.
  - If the channel was in ACC, `proto_err` also pulses.
  - The channel ends in IDLE with `acc = 0`.
- A mismatch sets `err_sticky[ch]` and increments `err_cnt`. The counter stops at all-ones.
- `err_clr` has priority over a mismatch in the same cycle: both the flags and the counter clear, and that mismatch is not recorded.
- A low `reset` in the middle of a packet discards all partial CRCs. Flits arriving after reset that continue the old packet are treated as protocol errors.

## Timing
- `crc_done`, `crc_done_channel`, `crc_ok` and `proto_err` are registered. They are valid exactly 1 cycle after the flit that triggers them and last one cycle. All reset to 0.
- `err_sticky` and `err_cnt` update 1 cycle after the tail flit, in the same cycle as `crc_done`. Both reset to 0.
- Back-to-back flits on the same channel are supported on every cycle; a head flit may follow a tail flit with no gap.
- Interleaving flits of different channels cycle by cycle has no effect on each channel's CRC.
- Single accumulator: one XOR matrix, with its input muxed by `flit_channel`.

## Configuration
- `NI_CRC_ERR_CNT_EN` defined:
  - `err_cnt` counter and the counter clear by `err_clr` are implemented as described above.
- `NI_CRC_ERR_CNT_EN` not defined:
  - No counter hardware is built and `err_cnt` is tied to 0.
  - `err_sticky` and `err_clr` still operate.

## Test plan
- Basic pass: channel 0, head 0x00000001 then tail 0x04C11DB7. Expect `crc_done`=1, `crc_ok`=1, `crc_done_channel`=0 one cycle later; `err_cnt` stays 0.
- Mismatch: channel 1, head 0x00000001 then tail 0x04C11DB6. Expect `crc_ok`=0, `err_sticky`=4'b0010, `err_cnt`=1. Then pulse `err_clr`: expect flags and counter back to 0.
- Interleave: channel 2 head 0x00000001, channel 3 head 0, channel 3 body 0, channel 2 tail 0x04C11DB7, channel 3 tail 0. Expect two passes, on channel 2 and then channel 3, each one cycle after its tail.
- Protocol errors: body flit on an IDLE channel, then tail flit on an IDLE channel. Expect a `proto_err` pulse for each and no `crc_done`. Single flit head+tail with data 0 → `crc_ok`=1; with data 5 → `crc_ok`=0.
- Saturation and reset (build with ERR_CNT_W=2 and `NI_CRC_ERR_CNT_EN` defined): 5 failing packets → `err_cnt`=3. Drive `reset` low in the middle of a packet: all outputs go to 0 immediately; the following tail flit gives `proto_err`.
